// File: rtl/id_stage_param.sv
// -----------------------------------------------------------------------------
// id_stage_param
//   RV32 instruction decode stage sitting between IF and EX.
//   - Decodes one instruction into a one-hot class, destination and immediate.
//   - Reads two register-file operands and overrides them from NUM_FWD
//     forwarding sources (index 0 is the youngest and wins).
//   - Stalls while a selected forwarding source is still pending (load in
//     flight) for a register the instruction actually reads.
//   - Computes branch / JAL / JALR targets.
//   - Single-entry output register with valid/ready on both sides and a
//     flush input that kills the held bundle.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         IF-side handshake, in_pc/in_inst payload
//   flush                     kill the held bundle; blocks acceptance this cycle
//   rf_raddr1/2, rf_rdata1/2  combinational register-file read port
//   fwd_valid/pending/addr/data  forwarding sources, packed, index 0 youngest
//   out_valid/out_ready       EX-side handshake
//   out_pc .. out_illegal     registered decoded bundle
//   perf_stall_cnt            cycles the interlock stalled (not during flush)
//   perf_mem_cnt              accepted loads and stores
// -----------------------------------------------------------------------------
module id_stage_param #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 3,
    parameter int M_EXT   = 1,
    parameter int PERF_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [31:0]             in_inst,
    input  logic                    flush,
    output logic [4:0]              rf_raddr1,
    output logic [4:0]              rf_raddr2,
    input  logic [XLEN-1:0]         rf_rdata1,
    input  logic [XLEN-1:0]         rf_rdata2,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [NUM_FWD*5-1:0]    fwd_addr,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output logic [XLEN-1:0]         out_rs1_val,
    output logic [XLEN-1:0]         out_rs2_val,
    output logic [XLEN-1:0]         out_imm,
    output logic [XLEN-1:0]         out_target,
    output logic [4:0]              out_rd,
    output logic [9:0]              out_class,
    output logic [2:0]              out_funct3,
    output logic [6:0]              out_funct7,
    output logic                    out_illegal,
    output logic [PERF_W-1:0]       perf_stall_cnt,
    output logic [PERF_W-1:0]       perf_mem_cnt
);

    // Bit positions inside the one-hot class vector {R,I,LOAD,JALR,S,B,LUI,AUIPC,JAL,MUL}
    localparam int CLS_R     = 9;
    localparam int CLS_I     = 8;
    localparam int CLS_LOAD  = 7;
    localparam int CLS_JALR  = 6;
    localparam int CLS_S     = 5;
    localparam int CLS_B     = 4;
    localparam int CLS_LUI   = 3;
    localparam int CLS_AUIPC = 2;
    localparam int CLS_JAL   = 1;
    localparam int CLS_MUL   = 0;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Returns {pending, value} of the operand for register rs. x0 is always
    // zero and never pending; otherwise the lowest-index matching forwarding
    // source wins, so the loop runs from the oldest down to the youngest.
    function automatic logic [XLEN:0] pick_operand(
        input logic [4:0]              rs,
        input logic [XLEN-1:0]         rdata,
        input logic [NUM_FWD-1:0]      f_valid,
        input logic [NUM_FWD-1:0]      f_pending,
        input logic [NUM_FWD*5-1:0]    f_addr,
        input logic [NUM_FWD*XLEN-1:0] f_data
    );
        logic [XLEN:0] res;
        res = {1'b0, rdata};
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (f_valid[i] && (f_addr[i*5 +: 5] == rs)) begin
                res = {f_pending[i], f_data[i*XLEN +: XLEN]};
            end
        end
        if (rs == 5'd0) begin
            res = {1'b0, {XLEN{1'b0}}};
        end
        return res;
    endfunction

    logic [6:0]      opcode_s;
    logic [9:0]      cls_s;
    logic            illegal_s;
    logic [31:0]     imm32_s;
    logic [XLEN-1:0] imm_s;
    logic [XLEN:0]   op1_s;
    logic [XLEN:0]   op2_s;
    logic            uses_rs1_s;
    logic            uses_rs2_s;
    logic            hazard_s;
    logic            in_ready_s;
    logic            accept_s;
    logic [XLEN-1:0] jalr_sum_s;
    logic [XLEN-1:0] target_s;
    logic [4:0]      rd_s;
    logic            is_mem_s;

    logic              valid_q, valid_d;
    logic [XLEN-1:0]   pc_q, rs1_val_q, rs2_val_q, imm_q, target_q;
    logic [4:0]        rd_q;
    logic [9:0]        class_q;
    logic [2:0]        funct3_q;
    logic [6:0]        funct7_q;
    logic              illegal_q;
    logic [PERF_W-1:0] stall_cnt_q;
    logic [PERF_W-1:0] mem_cnt_q;

    assign opcode_s  = in_inst[6:0];
    assign rf_raddr1 = in_inst[19:15];
    assign rf_raddr2 = in_inst[24:20];

    // Opcode decode into the one-hot class and the illegal flag
    always_comb begin
        cls_s     = 10'd0;
        illegal_s = 1'b0;
        case (opcode_s)
            OPC_OP: begin
                if (in_inst[31:25] == 7'b0000001) begin
                    if (M_EXT != 32'sd0) begin
                        cls_s[CLS_MUL] = 1'b1;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    cls_s[CLS_R] = 1'b1;
                end
            end
            OPC_OP_IMM: cls_s[CLS_I]     = 1'b1;
            OPC_LOAD:   cls_s[CLS_LOAD]  = 1'b1;
            OPC_JALR:   cls_s[CLS_JALR]  = 1'b1;
            OPC_STORE:  cls_s[CLS_S]     = 1'b1;
            OPC_BRANCH: cls_s[CLS_B]     = 1'b1;
            OPC_LUI:    cls_s[CLS_LUI]   = 1'b1;
            OPC_AUIPC:  cls_s[CLS_AUIPC] = 1'b1;
            OPC_JAL:    cls_s[CLS_JAL]   = 1'b1;
            default:    illegal_s        = 1'b1;
        endcase
    end

    // Immediate builder; R-type, MUL and illegal encodings carry no immediate
    always_comb begin
        if (cls_s[CLS_I] || cls_s[CLS_LOAD] || cls_s[CLS_JALR]) begin
            imm32_s = {{20{in_inst[31]}}, in_inst[31:20]};
        end else if (cls_s[CLS_S]) begin
            imm32_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        end else if (cls_s[CLS_B]) begin
            imm32_s = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
        end else if (cls_s[CLS_LUI] || cls_s[CLS_AUIPC]) begin
            imm32_s = {in_inst[31:12], 12'd0};
        end else if (cls_s[CLS_JAL]) begin
            imm32_s = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
        end else begin
            imm32_s = 32'd0;
        end
    end

    // Sign-extend to XLEN so the same code serves an RV64 build
    assign imm_s = XLEN'($signed(imm32_s));

    assign op1_s = pick_operand(rf_raddr1, rf_rdata1, fwd_valid, fwd_pending, fwd_addr, fwd_data);
    assign op2_s = pick_operand(rf_raddr2, rf_rdata2, fwd_valid, fwd_pending, fwd_addr, fwd_data);

    assign uses_rs1_s = cls_s[CLS_R] | cls_s[CLS_I] | cls_s[CLS_LOAD] | cls_s[CLS_JALR] |
                        cls_s[CLS_S] | cls_s[CLS_B] | cls_s[CLS_MUL];
    assign uses_rs2_s = cls_s[CLS_R] | cls_s[CLS_S] | cls_s[CLS_B] | cls_s[CLS_MUL];

    // Only the selected source's pending bit matters: a shadowed older pending
    // entry is irrelevant because its value would not be used anyway.
    assign hazard_s   = in_valid & ((uses_rs1_s & op1_s[XLEN]) | (uses_rs2_s & op2_s[XLEN]));
    assign in_ready_s = (~valid_q | out_ready) & ~hazard_s & ~flush;
    assign accept_s   = in_valid & in_ready_s;
    assign in_ready   = in_ready_s;

    assign jalr_sum_s = op1_s[XLEN-1:0] + imm_s;
    assign rd_s       = (cls_s[CLS_S] | cls_s[CLS_B] | illegal_s) ? 5'd0 : in_inst[11:7];
    assign is_mem_s   = cls_s[CLS_LOAD] | cls_s[CLS_S];

    // Branch/jump target selection
    always_comb begin
        if (cls_s[CLS_B] || cls_s[CLS_JAL]) begin
            target_s = in_pc + imm_s;
        end else if (cls_s[CLS_JALR]) begin
            target_s = {jalr_sum_s[XLEN-1:1], 1'b0};
        end else begin
            target_s = {XLEN{1'b0}};
        end
    end

    // Output-valid next state: flush beats accept, accept beats drain
    always_comb begin
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept_s) begin
            valid_d = 1'b1;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Pipeline register and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= {XLEN{1'b0}};
            rs1_val_q   <= {XLEN{1'b0}};
            rs2_val_q   <= {XLEN{1'b0}};
            imm_q       <= {XLEN{1'b0}};
            target_q    <= {XLEN{1'b0}};
            rd_q        <= 5'd0;
            class_q     <= 10'd0;
            funct3_q    <= 3'd0;
            funct7_q    <= 7'd0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= {PERF_W{1'b0}};
            mem_cnt_q   <= {PERF_W{1'b0}};
        end else begin
            valid_q <= valid_d;
            if (accept_s) begin
                pc_q      <= in_pc;
                rs1_val_q <= op1_s[XLEN-1:0];
                rs2_val_q <= op2_s[XLEN-1:0];
                imm_q     <= imm_s;
                target_q  <= target_s;
                rd_q      <= rd_s;
                class_q   <= cls_s;
                funct3_q  <= in_inst[14:12];
                funct7_q  <= in_inst[31:25];
                illegal_q <= illegal_s;
            end
            if (hazard_s && !flush) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1'b1);
            end
            if (accept_s && is_mem_s) begin
                mem_cnt_q <= mem_cnt_q + PERF_W'(1'b1);
            end
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = pc_q;
    assign out_rs1_val    = rs1_val_q;
    assign out_rs2_val    = rs2_val_q;
    assign out_imm        = imm_q;
    assign out_target     = target_q;
    assign out_rd         = rd_q;
    assign out_class      = class_q;
    assign out_funct3     = funct3_q;
    assign out_funct7     = funct7_q;
    assign out_illegal    = illegal_q;
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_mem_cnt   = mem_cnt_q;

endmodule

// File: tb/tb_id_stage_param.sv
// -----------------------------------------------------------------------------
// tb_id_stage_param
//   Directed scenarios followed by randomized traffic. A behavioural model of
//   the decode stage predicts every output each cycle; a few literal values
//   pin the model on hand-worked instructions. A second instance built
//   without the M extension checks MUL is reported illegal there.
// -----------------------------------------------------------------------------
module tb_id_stage_param;
    localparam int XLEN = 32;
    localparam int NF   = 3;
    localparam int PW   = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, in_valid, flush, out_ready;
    logic [31:0]       in_pc, in_inst;
    logic [NF-1:0]     fwd_valid, fwd_pending;
    logic [NF*5-1:0]   fwd_addr;
    logic [NF*32-1:0]  fwd_data;
    logic [31:0]       rf_mem [32];

    logic              in_ready, out_valid, out_illegal;
    logic [4:0]        rf_raddr1, rf_raddr2, out_rd;
    logic [31:0]       rf_rdata1, rf_rdata2;
    logic [31:0]       out_pc, out_rs1_val, out_rs2_val, out_imm, out_target;
    logic [9:0]        out_class;
    logic [2:0]        out_funct3;
    logic [6:0]        out_funct7;
    logic [PW-1:0]     perf_stall_cnt, perf_mem_cnt;

    logic              d2_in_ready, d2_out_valid, d2_out_illegal;
    logic [4:0]        d2_raddr1, d2_raddr2, d2_out_rd;
    logic [31:0]       d2_rdata1, d2_rdata2;
    logic [31:0]       d2_out_pc, d2_out_rs1, d2_out_rs2, d2_out_imm, d2_out_target;
    logic [9:0]        d2_out_class;
    logic [2:0]        d2_out_funct3;
    logic [6:0]        d2_out_funct7;
    logic [PW-1:0]     d2_stall, d2_mem;

    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];
    assign d2_rdata1 = rf_mem[d2_raddr1];
    assign d2_rdata2 = rf_mem[d2_raddr2];

    id_stage_param #(.XLEN(XLEN), .NUM_FWD(NF), .M_EXT(1), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_imm(out_imm), .out_target(out_target), .out_rd(out_rd),
        .out_class(out_class), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_illegal(out_illegal),
        .perf_stall_cnt(perf_stall_cnt), .perf_mem_cnt(perf_mem_cnt)
    );

    id_stage_param #(.XLEN(XLEN), .NUM_FWD(NF), .M_EXT(0), .PERF_W(PW)) dut_nom (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .flush(flush),
        .rf_raddr1(d2_raddr1), .rf_raddr2(d2_raddr2),
        .rf_rdata1(d2_rdata1), .rf_rdata2(d2_rdata2),
        .fwd_valid(fwd_valid), .fwd_pending(fwd_pending),
        .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .out_valid(d2_out_valid), .out_ready(out_ready),
        .out_pc(d2_out_pc), .out_rs1_val(d2_out_rs1), .out_rs2_val(d2_out_rs2),
        .out_imm(d2_out_imm), .out_target(d2_out_target), .out_rd(d2_out_rd),
        .out_class(d2_out_class), .out_funct3(d2_out_funct3), .out_funct7(d2_out_funct7),
        .out_illegal(d2_out_illegal),
        .perf_stall_cnt(d2_stall), .perf_mem_cnt(d2_mem)
    );

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model of the registered bundle and counters
    bit          m_valid = 1'b0;
    logic [31:0] m_pc = '0, m_rs1 = '0, m_rs2 = '0, m_imm = '0, m_tgt = '0;
    logic [4:0]  m_rd = '0;
    logic [9:0]  m_cls = '0;
    logic [2:0]  m_f3 = '0;
    logic [6:0]  m_f7 = '0;
    bit          m_ill = 1'b0;
    logic [31:0] m_stall = '0, m_mem = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Class index: 0=R 1=I 2=LOAD 3=JALR 4=S 5=B 6=LUI 7=AUIPC 8=JAL 9=MUL, -1 illegal
    function automatic void model_decode(input logic [31:0] inst, output int k, output logic [31:0] imm);
        int s;
        s = $signed(inst);
        case (inst[6:0])
            7'h33: k = (inst[31:25] == 7'd1) ? 9 : 0;
            7'h13: k = 1;
            7'h03: k = 2;
            7'h67: k = 3;
            7'h23: k = 4;
            7'h63: k = 5;
            7'h37: k = 6;
            7'h17: k = 7;
            7'h6F: k = 8;
            default: k = -1;
        endcase
        case (k)
            1, 2, 3: imm = s >>> 20;
            4:       imm = (s >>> 25) * 32 + int'(inst[11:7]);
            5:       imm = (s >>> 31) * 4096 + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
            6, 7:    imm = inst & 32'hFFFFF000;
            8:       imm = (s >>> 31) * 1048576 + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
            default: imm = 32'd0;
        endcase
    endfunction

    function automatic void model_opnd(input logic [4:0] rs, output logic [31:0] val, output bit pend);
        val  = rf_mem[rs];
        pend = 1'b0;
        if (rs == 5'd0) begin
            val = 32'd0;
            return;
        end
        for (int i = 0; i < NF; i++) begin
            if (fwd_valid[i] && fwd_addr[i*5 +: 5] == rs) begin
                val  = fwd_data[i*32 +: 32];
                pend = fwd_pending[i];
                return;
            end
        end
    endfunction

    // One clock: check combinational outputs at negedge, advance model at posedge, compare #1 later
    task automatic step();
        int k;
        logic [31:0] imm, v1, v2;
        logic [9:0]  top;
        bit p1, p2, u1, u2, hz, rdy, acc;
        top = 10'b10_0000_0000;
        @(negedge clk);
        model_decode(in_inst, k, imm);
        model_opnd(in_inst[19:15], v1, p1);
        model_opnd(in_inst[24:20], v2, p2);
        u1  = k inside {0, 1, 2, 3, 4, 5, 9};
        u2  = k inside {0, 4, 5, 9};
        hz  = in_valid && ((u1 && p1) || (u2 && p2));
        rdy = (!m_valid || out_ready) && !hz && !flush;
        acc = in_valid && rdy;
        chk("in_ready", in_ready, rdy);
        chk("rf_raddr1", rf_raddr1, in_inst[19:15]);
        chk("rf_raddr2", rf_raddr2, in_inst[24:20]);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_tgt = 0;
            m_rd = 0; m_cls = 0; m_f3 = 0; m_f7 = 0; m_ill = 0; m_stall = 0; m_mem = 0;
        end else begin
            if (hz && !flush) m_stall = m_stall + 1;
            if (acc && (k == 2 || k == 4)) m_mem = m_mem + 1;
            if (flush) begin
                m_valid = 0;
            end else if (acc) begin
                m_valid = 1;
                m_pc  = in_pc;
                m_rs1 = v1;
                m_rs2 = v2;
                m_imm = imm;
                m_cls = (k < 0) ? 10'd0 : (top >> k);
                m_rd  = (k < 0 || k == 4 || k == 5) ? 5'd0 : in_inst[11:7];
                m_f3  = in_inst[14:12];
                m_f7  = in_inst[31:25];
                m_ill = (k < 0);
                if (k == 5 || k == 8) m_tgt = in_pc + imm;
                else if (k == 3)      m_tgt = (v1 + imm) & 32'hFFFF_FFFE;
                else                  m_tgt = 32'd0;
            end else if (out_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk("out_valid", out_valid, m_valid);
        chk("out_pc", out_pc, m_pc);
        chk("out_rs1_val", out_rs1_val, m_rs1);
        chk("out_rs2_val", out_rs2_val, m_rs2);
        chk("out_imm", out_imm, m_imm);
        chk("out_target", out_target, m_tgt);
        chk("out_rd", out_rd, m_rd);
        chk("out_class", out_class, m_cls);
        chk("out_funct3", out_funct3, m_f3);
        chk("out_funct7", out_funct7, m_f7);
        chk("out_illegal", out_illegal, m_ill);
        chk("perf_stall_cnt", perf_stall_cnt, m_stall);
        chk("perf_mem_cnt", perf_mem_cnt, m_mem);
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
    endtask

    logic [6:0] ops [11];

    initial begin
        ops = '{7'h33, 7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
        for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
        rf_mem[0] = 32'hDEAD_BEEF;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        in_pc = 32'd0; in_inst = 32'd0;
        fwd_valid = '0; fwd_pending = '0; fwd_addr = '0; fwd_data = '0;

        // 1. reset, then addi x1,x0,5
        step(); step();
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_stall", perf_stall_cnt, 32'd0);
        rst = 1'b0;
        present(32'h0, 32'h0050_0093);
        step();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_class", out_class, 10'b01_0000_0000);
        chk("t1_rd", out_rd, 5'd1);
        chk("t1_imm", out_imm, 32'd5);
        chk("t1_rs1", out_rs1_val, 32'd0);

        // 2. add x3,x1,x2 with youngest forward winning over WB
        rf_mem[1] = 32'd7; rf_mem[2] = 32'h22;
        fwd_valid = 3'b101;
        fwd_addr  = {5'd1, 5'd9, 5'd1};
        fwd_data  = {32'h20, 32'h99, 32'h10};
        present(32'h4, 32'h0020_81B3);
        step();
        chk("t2_rs1_fwd0", out_rs1_val, 32'h10);
        chk("t2_rs2_rf", out_rs2_val, 32'h22);

        // 3. sub x6,x5,x4 waiting on a pending load to x5 at MEM
        fwd_valid = 3'b010; fwd_pending = 3'b010;
        fwd_addr  = {5'd0, 5'd5, 5'd0};
        fwd_data  = {32'h0, 32'h0, 32'h0};
        present(32'h8, 32'h4042_8333);
        step(); step();
        chk("t3_stall_cnt", perf_stall_cnt, 32'd2);
        chk("t3_model_stall", m_stall, 32'd2);
        fwd_pending = 3'b000;
        fwd_data    = {32'h0, 32'hAB, 32'h0};
        step();
        chk("t3_rs1_ab", out_rs1_val, 32'hAB);
        fwd_valid = '0;

        // 4. back-pressure for three cycles, then flush
        present(32'h200, 32'h0010_0393);
        step();
        out_ready = 1'b0;
        present(32'h204, 32'h0020_0413);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_pc", out_pc, 32'h200);
            chk("t4_in_ready", in_ready, 1'b0);
        end
        flush = 1'b1;
        step();
        chk("t4_flush_valid", out_valid, 1'b0);
        chk("t4_not_consumed", out_pc, 32'h200);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();

        // 5. jalr x1,-4(x2) and beq with negative offset
        rf_mem[2] = 32'h1003;
        present(32'h300, 32'hFFC1_00E7);
        step();
        chk("t5_jalr_tgt", out_target, 32'hFFE);
        chk("t5_jalr_class", out_class, 10'b00_0100_0000);
        chk("t5_model_tgt", m_tgt, 32'hFFE);
        present(32'h100, 32'hFE00_0CE3);
        step();
        chk("t5_beq_tgt", out_target, 32'hF8);
        chk("t5_beq_rd", out_rd, 5'd0);
        chk("t5_model_imm", m_imm, 32'hFFFF_FFF8);

        // 6. illegal opcode, MUL with and without M, store+load counting
        present(32'h400, 32'h0000_0FFF);
        step();
        chk("t6_illegal", out_illegal, 1'b1);
        chk("t6_rd", out_rd, 5'd0);
        present(32'h404, 32'h0231_00B3);
        step();
        chk("t6_mul_class", out_class, 10'b00_0000_0001);
        chk("t6_nom_illegal", d2_out_illegal, 1'b1);
        chk("t6_nom_rd", d2_out_rd, 5'd0);
        present(32'h408, 32'h0031_2423);
        step();
        present(32'h40C, 32'h0041_2283);
        step();
        chk("t6_mem_cnt", perf_mem_cnt, 32'd2);
        in_valid = 1'b0;
        step();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int kind;
            logic [31:0] w;
            kind = $urandom_range(0, 10);
            w = $urandom;
            w[6:0]   = ops[kind];
            if (kind == 0) w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20;
            if (kind == 1) w[31:25] = 7'h01;
            if (kind == 10 && $urandom_range(0, 1) == 0) w[6:0] = 7'h0B;
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            w[11:7]  = 5'($urandom_range(0, 7));
            in_inst   = w;
            in_pc     = $urandom & 32'hFFFF_FFFC;
            in_valid  = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            rst       = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NF; i++) begin
                fwd_valid[i]       = $urandom_range(0, 1);
                fwd_pending[i]     = ($urandom_range(0, 3) == 0);
                fwd_addr[i*5 +: 5] = 5'($urandom_range(0, 7));
                fwd_data[i*32 +: 32] = $urandom;
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
